// File: rtl/hazard_ctrl_p.sv
// Hazard controller for the 5-stage pipeline: tracks in-flight destinations and
// generates registered forwarding selects, load-use stalls, branch flushes and memory freeze.
module hazard_ctrl_p #(
  parameter int unsigned REG_W    = 4,
  parameter int unsigned NPORTS   = 2,
  parameter int unsigned BR_STAGE = 3,
  parameter int unsigned R0_ZERO  = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NPORTS*REG_W-1:0]   id_src,
  input  logic [NPORTS-1:0]         id_src_use,
  input  logic [REG_W-1:0]          id_dst,
  input  logic                      id_wr_en,
  input  logic                      id_is_load,
  input  logic                      br_taken,
  input  logic                      mem_busy,
  output logic [2*NPORTS-1:0]       fwd_sel,
  output logic                      pc_en,
  output logic                      id_ex_en,
  output logic                      ex_mem_en,
  output logic [2:0]                flush,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dst;
    logic             ld;
  } slot_t;

  typedef enum logic [1:0] {ACT_RUN, ACT_STALL, ACT_FLUSH, ACT_FREEZE} act_e;

  // No WB slot is kept: WB producers are never forwarded because the register
  // file writes before it reads, so that slot has no effect on any output.
  slot_t                ex_q, ex_d, mem_q, mem_d;
  logic [2*NPORTS-1:0]  fwd_q, fwd_d, fwd_calc;
  logic [CNT_W-1:0]     scnt_q, scnt_d, fcnt_q, fcnt_d;
  logic [NPORTS-1:0]    m_ex, m_mem;
  logic                 lu;
  act_e                 act;

  always_comb begin
    logic [REG_W-1:0] src_p;
    logic             r0;
    m_ex     = '0;
    m_mem    = '0;
    fwd_calc = '0;
    src_p    = '0;
    r0       = 1'b0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      src_p    = id_src[p*REG_W +: REG_W];
      r0       = (R0_ZERO != 0) && (src_p == '0);
      m_ex[p]  = ex_q.v  & id_src_use[p] & (ex_q.dst  == src_p) & ~r0;
      m_mem[p] = mem_q.v & id_src_use[p] & (mem_q.dst == src_p) & ~r0;
      // Youngest producer first; a load still in EX is covered by the stall.
      if (m_ex[p] && !ex_q.ld) fwd_calc[2*p +: 2] = 2'b01;
      else if (m_mem[p])       fwd_calc[2*p +: 2] = 2'b10;
    end
  end

  assign lu = id_valid & (|m_ex) & ex_q.ld;

  always_comb begin
    if (mem_busy)      act = ACT_FREEZE;
    else if (br_taken) act = ACT_FLUSH;
    else if (lu)       act = ACT_STALL;
    else               act = ACT_RUN;
  end

  always_comb begin
    pc_en     = 1'b1;
    id_ex_en  = 1'b1;
    ex_mem_en = 1'b1;
    flush     = '0;
    unique case (act)
      ACT_FREEZE: begin
        pc_en     = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
      end
      ACT_FLUSH: flush = (BR_STAGE == 3) ? 3'b111 : 3'b011;
      ACT_STALL: begin
        pc_en    = 1'b0;
        id_ex_en = 1'b0;
        flush    = 3'b010;
      end
      default: ;
    endcase
  end

  always_comb begin
    ex_d   = ex_q;
    mem_d  = mem_q;
    fwd_d  = fwd_q;
    scnt_d = scnt_q;
    fcnt_d = fcnt_q;
    unique case (act)
      ACT_RUN: begin
        mem_d   = ex_q;
        ex_d.v  = id_valid & id_wr_en;
        ex_d.dst = id_dst;
        ex_d.ld = id_is_load;
        fwd_d   = fwd_calc;
      end
      ACT_STALL: begin
        mem_d = ex_q;
        ex_d  = '0;
        fwd_d = '0;
        if (scnt_q != '1) scnt_d = scnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      ACT_FLUSH: begin
        // Resolving in MEM kills the instruction in EX as it moves into MEM.
        mem_d = ex_q;
        if (BR_STAGE == 3) mem_d.v = 1'b0;
        ex_d  = '0;
        fwd_d = '0;
        if (fcnt_q != '1) fcnt_d = fcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q   <= '0;
      mem_q  <= '0;
      fwd_q  <= '0;
      scnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      fwd_q  <= fwd_d;
      scnt_q <= scnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign fwd_sel   = fwd_q;
  assign stall_cnt = scnt_q;
  assign flush_cnt = fcnt_q;

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Self-checking bench for hazard_ctrl_p: vector table with a scoreboard for the
// registered outputs, plus hand-written reset and NPORTS=3 / BR_STAGE=2 sequences.
module tb_hazard_ctrl_p;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_valid, a_wr, a_ld, a_br, a_busy;
  logic [7:0]  a_src;
  logic [1:0]  a_use;
  logic [3:0]  a_dst, a_fwd;
  logic        a_pc, a_idex, a_exmem;
  logic [2:0]  a_flush;
  logic [15:0] a_scnt, a_fcnt;

  logic        b_valid, b_wr, b_ld, b_br, b_busy;
  logic [11:0] b_src;
  logic [2:0]  b_use;
  logic [3:0]  b_dst;
  logic [5:0]  b_fwd;
  logic        b_pc, b_idex, b_exmem;
  logic [2:0]  b_flush;
  logic [1:0]  b_scnt, b_fcnt;

  hazard_ctrl_p #(.REG_W(4), .NPORTS(2), .BR_STAGE(3), .R0_ZERO(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(a_valid), .id_src(a_src), .id_src_use(a_use),
    .id_dst(a_dst), .id_wr_en(a_wr), .id_is_load(a_ld), .br_taken(a_br), .mem_busy(a_busy),
    .fwd_sel(a_fwd), .pc_en(a_pc), .id_ex_en(a_idex), .ex_mem_en(a_exmem), .flush(a_flush),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

  hazard_ctrl_p #(.REG_W(4), .NPORTS(3), .BR_STAGE(2), .R0_ZERO(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(b_valid), .id_src(b_src), .id_src_use(b_use),
    .id_dst(b_dst), .id_wr_en(b_wr), .id_is_load(b_ld), .br_taken(b_br), .mem_busy(b_busy),
    .fwd_sel(b_fwd), .pc_en(b_pc), .id_ex_en(b_idex), .ex_mem_en(b_exmem), .flush(b_flush),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       v;
    logic [3:0] s1, s0;
    logic [1:0] su;
    logic [3:0] dst;
    logic       wr, ld, br, busy;
    logic [2:0] en, fl;
    logic [3:0] fwd;
    int         sc, fc;
  } vec_t;

  typedef struct {
    logic [3:0] fwd;
    int         sc, fc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [3:0] s1, input logic [3:0] s0,
                              input logic [1:0] su, input logic [3:0] dst, input logic wr,
                              input logic ld, input logic br, input logic busy,
                              input logic [2:0] en, input logic [2:0] fl,
                              input logic [3:0] fwd, input int sc, input int fc);
    vec_t t;
    t.v = v; t.s1 = s1; t.s0 = s0; t.su = su; t.dst = dst; t.wr = wr; t.ld = ld;
    t.br = br; t.busy = busy; t.en = en; t.fl = fl; t.fwd = fwd; t.sc = sc; t.fc = fc;
    return t;
  endfunction

  task automatic step_a(input vec_t t, input string tag);
    exp_t e;
    a_valid = t.v; a_src = {t.s1, t.s0}; a_use = t.su; a_dst = t.dst;
    a_wr = t.wr; a_ld = t.ld; a_br = t.br; a_busy = t.busy;
    sb.push_back('{fwd: t.fwd, sc: t.sc, fc: t.fc});
    @(negedge clk);
    chk({tag, " en"}, {29'd0, a_pc, a_idex, a_exmem}, {29'd0, t.en});
    chk({tag, " flush"}, {29'd0, a_flush}, {29'd0, t.fl});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, " fwd"}, {28'd0, a_fwd}, {28'd0, e.fwd});
    chk({tag, " stall_cnt"}, {16'd0, a_scnt}, e.sc);
    chk({tag, " flush_cnt"}, {16'd0, a_fcnt}, e.fc);
  endtask

  task automatic step_b(input logic [11:0] src, input logic [2:0] su, input logic [3:0] dst,
                        input logic wr, input logic ld, input logic br,
                        input logic [2:0] en, input logic [2:0] fl, input logic [5:0] fwd,
                        input int sc, input int fc, input string tag);
    b_valid = 1'b1; b_src = src; b_use = su; b_dst = dst;
    b_wr = wr; b_ld = ld; b_br = br; b_busy = 1'b0;
    @(negedge clk);
    chk({tag, " en"}, {29'd0, b_pc, b_idex, b_exmem}, {29'd0, en});
    chk({tag, " flush"}, {29'd0, b_flush}, {29'd0, fl});
    @(posedge clk); #1;
    chk({tag, " fwd"}, {26'd0, b_fwd}, {26'd0, fwd});
    chk({tag, " stall_cnt"}, {30'd0, b_scnt}, sc);
    chk({tag, " flush_cnt"}, {30'd0, b_fcnt}, fc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 0; a_src = '0; a_use = '0; a_dst = '0; a_wr = 0; a_ld = 0; a_br = 0; a_busy = 0;
    b_valid = 0; b_src = '0; b_use = '0; b_dst = '0; b_wr = 0; b_ld = 0; b_br = 0; b_busy = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst fwd", {28'd0, a_fwd}, 32'd0);
    chk("rst stall_cnt", {16'd0, a_scnt}, 32'd0);
    chk("rst flush_cnt", {16'd0, a_fcnt}, 32'd0);
    chk("rst en", {29'd0, a_pc, a_idex, a_exmem}, 32'd7);
    chk("rst flush", {29'd0, a_flush}, 32'd0);
    rst_n = 1'b1;

    //            v  s1  s0  su     dst wr ld br bz en      fl      fwd      sc fc
    tbl.push_back(mk(1, 0,  0,  2'b00, 3,  1, 0, 0, 0, 3'b111, 3'b000, 4'b0000, 0, 0)); // add r3
    tbl.push_back(mk(1, 1,  3,  2'b11, 4,  1, 0, 0, 0, 3'b111, 3'b000, 4'b0001, 0, 0)); // add r4,r3,r1
    tbl.push_back(mk(1, 10, 9,  2'b11, 7,  1, 0, 0, 0, 3'b111, 3'b000, 4'b0000, 0, 0)); // independent
    tbl.push_back(mk(1, 7,  4,  2'b11, 9,  1, 0, 0, 0, 3'b111, 3'b000, 4'b0110, 0, 0)); // r4 from WB, r7 from MEM
    tbl.push_back(mk(1, 0,  0,  2'b00, 9,  1, 0, 0, 0, 3'b111, 3'b000, 4'b0000, 0, 0)); // r9 twice in flight
    tbl.push_back(mk(1, 9,  9,  2'b01, 2,  1, 0, 0, 0, 3'b111, 3'b000, 4'b0001, 0, 0)); // youngest wins, p1 unused
    tbl.push_back(mk(1, 0,  0,  2'b00, 5,  1, 1, 0, 0, 3'b111, 3'b000, 4'b0000, 0, 0)); // ld r5
    tbl.push_back(mk(1, 2,  5,  2'b11, 6,  1, 0, 0, 0, 3'b001, 3'b010, 4'b0000, 1, 0)); // load-use stall
    tbl.push_back(mk(1, 2,  5,  2'b11, 6,  1, 0, 0, 0, 3'b111, 3'b000, 4'b0010, 1, 0)); // load from WB, r2 not fwd
    tbl.push_back(mk(1, 0,  0,  2'b00, 8,  1, 1, 0, 0, 3'b111, 3'b000, 4'b0000, 1, 0)); // ld r8
    tbl.push_back(mk(1, 0,  8,  2'b01, 10, 1, 0, 1, 0, 3'b111, 3'b111, 4'b0000, 1, 1)); // branch beats load-use
    tbl.push_back(mk(1, 6,  8,  2'b11, 11, 1, 0, 0, 0, 3'b111, 3'b000, 4'b0000, 1, 1)); // flushed r8 gone
    tbl.push_back(mk(1, 0,  0,  2'b00, 0,  1, 0, 0, 0, 3'b111, 3'b000, 4'b0000, 1, 1)); // write r0
    tbl.push_back(mk(1, 0,  0,  2'b11, 12, 1, 0, 0, 0, 3'b111, 3'b000, 4'b0000, 1, 1)); // read r0
    tbl.push_back(mk(1, 0,  0,  2'b00, 13, 1, 1, 0, 0, 3'b111, 3'b000, 4'b0000, 1, 1)); // ld r13
    tbl.push_back(mk(1, 13, 13, 2'b00, 14, 1, 0, 0, 0, 3'b111, 3'b000, 4'b0000, 1, 1)); // unused ports, no stall
    tbl.push_back(mk(0, 0,  0,  2'b00, 14, 1, 0, 0, 0, 3'b111, 3'b000, 4'b0000, 1, 1)); // invalid ID
    tbl.push_back(mk(1, 0,  14, 2'b01, 0,  0, 0, 0, 0, 3'b111, 3'b000, 4'b0010, 1, 1)); // r14 from WB
    tbl.push_back(mk(1, 0,  0,  2'b00, 2,  1, 0, 0, 0, 3'b111, 3'b000, 4'b0000, 1, 1)); // add r2
    tbl.push_back(mk(1, 0,  2,  2'b01, 5,  1, 1, 0, 0, 3'b111, 3'b000, 4'b0001, 1, 1)); // ld r5,(r2)
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 0, 5, 2'b01, 6, 1, 0, 0, 1, 3'b000, 3'b000, 4'b0001, 1, 1)); // frozen stall
    tbl.push_back(mk(1, 0,  5,  2'b01, 6,  1, 0, 0, 0, 3'b001, 3'b010, 4'b0000, 2, 1)); // stall after release
    tbl.push_back(mk(1, 0,  5,  2'b01, 6,  1, 0, 0, 0, 3'b111, 3'b000, 4'b0010, 2, 1));
    tbl.push_back(mk(1, 0,  0,  2'b00, 7,  1, 0, 1, 1, 3'b000, 3'b000, 4'b0010, 2, 1)); // freeze beats branch
    tbl.push_back(mk(1, 0,  6,  2'b01, 7,  1, 0, 0, 0, 3'b111, 3'b000, 4'b0001, 2, 1));
    tbl.push_back(mk(1, 0,  0,  2'b00, 7,  1, 1, 0, 0, 3'b111, 3'b000, 4'b0000, 2, 1)); // ld r7

    foreach (tbl[i]) step_a(tbl[i], $sformatf("v%0d", i));

    // Reset asserted in the middle of a load-use stall
    a_valid = 1; a_src = 8'h07; a_use = 2'b01; a_dst = 4'd8; a_wr = 1; a_ld = 0; a_br = 0; a_busy = 0;
    @(negedge clk);
    chk("mid-stall pc_en", {31'd0, a_pc}, 32'd0);
    chk("mid-stall flush", {29'd0, a_flush}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst-async en", {29'd0, a_pc, a_idex, a_exmem}, 32'd7);
    chk("rst-async flush", {29'd0, a_flush}, 32'd0);
    chk("rst-async fwd", {28'd0, a_fwd}, 32'd0);
    chk("rst-async stall_cnt", {16'd0, a_scnt}, 32'd0);
    chk("rst-async flush_cnt", {16'd0, a_fcnt}, 32'd0);
    @(posedge clk); #1;
    chk("rst-held stall_cnt", {16'd0, a_scnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst en", {29'd0, a_pc, a_idex, a_exmem}, 32'd7);
    @(posedge clk); #1;
    chk("post-rst fwd", {28'd0, a_fwd}, 32'd0);
    chk("post-rst stall_cnt", {16'd0, a_scnt}, 32'd0);

    // NPORTS=3, BR_STAGE=2, 2-bit counters
    step_b(12'h000, 3'b000, 4'd9, 1, 0, 0, 3'b111, 3'b000, 6'h00, 0, 0, "b0");
    step_b(12'h909, 3'b100, 4'd3, 1, 0, 0, 3'b111, 3'b000, 6'h10, 0, 0, "b1 port2");
    step_b(12'h000, 3'b000, 4'd4, 1, 0, 1, 3'b111, 3'b011, 6'h00, 0, 1, "b2 branch EX");
    step_b(12'h030, 3'b010, 4'd5, 1, 0, 0, 3'b111, 3'b000, 6'h08, 0, 1, "b3 MEM kept");
    step_b(12'h000, 3'b000, 4'd0, 0, 0, 1, 3'b111, 3'b011, 6'h00, 0, 2, "b4");
    step_b(12'h000, 3'b000, 4'd0, 0, 0, 1, 3'b111, 3'b011, 6'h00, 0, 3, "b5");
    step_b(12'h000, 3'b000, 4'd0, 0, 0, 1, 3'b111, 3'b011, 6'h00, 0, 3, "b6 saturate");
    step_b(12'h000, 3'b000, 4'd8, 1, 1, 0, 3'b111, 3'b000, 6'h00, 0, 3, "b7 ld r8");
    step_b(12'h800, 3'b100, 4'd1, 1, 0, 0, 3'b001, 3'b010, 6'h00, 1, 3, "b8 lu port2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_p.md
Name: hazard_ctrl_p

Overview:
- Parametrised successor to the fixed 3-stage-compare forwarding unit of the 5-stage CPU (IF/ID/EX/MEM/WB).
- Tracks destination registers of in-flight instructions internally, instead of taking them from pipeline flops.
- Produces registered per-port forwarding selects, load-use stalls, branch flushes and a global freeze on memory wait.
- Sits beside ID; outputs drive pipeline-register enables/clears and the EX operand muxes.

Parameters:
- REG_W, 4, register-specifier width.
- NPORTS, 2, number of source-operand read ports checked.
- BR_STAGE, 3, stage resolving branches: 2 = EX, 3 = MEM.
- R0_ZERO, 1, when 1, register 0 is hardwired zero and never matches.
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NPORTS*REG_W  source specifiers; port p at [p*REG_W +: REG_W].
- id_src_use  in  NPORTS  port p actually reads its source.
- id_dst  in  REG_W  ID destination register.
- id_wr_en  in  1  ID instruction writes the register file.
- id_is_load  in  1  ID instruction is a load.
- br_taken  in  1  taken branch/jump resolved in BR_STAGE this cycle.
- mem_busy  in  1  data memory not ready; freeze whole pipeline.
- fwd_sel  out  2*NPORTS  per-port select for the instruction now in EX: 00 regfile/ID_EX value, 01 MEM-stage ALU result, 10 WB write data.
- pc_en  out  1  PC / IF_ID write enable.
- id_ex_en  out  1  ID_EX write enable.
- ex_mem_en  out  1  EX_MEM and MEM_WB write enable.
- flush  out  3  synchronous clears: bit0 IF_ID, bit1 ID_EX, bit2 EX_MEM.
- stall_cnt  out  CNT_W  cycles lost to load-use stalls.
- flush_cnt  out  CNT_W  taken-branch events.

Behaviour:
- State: three slots ex_q, mem_q, wb_q, each {v, dst, ld}.
- Reset: all slots v=0, fwd_sel=0, counters=0.
- Reset outputs combinational on zero state: pc_en=id_ex_en=ex_mem_en=1, flush=0.
- match(s,p) = s.v & id_src_use[p] & (s.dst == src_p) & ~(R0_ZERO & src_p == 0).
- Load-use: lu = id_valid & OR over p of match(ex_q,p) & ex_q.ld.
- Priority, highest first:
  - mem_busy: all enables 0, flush=0; slots, fwd_sel and counters hold.
  - br_taken: pc_en=id_ex_en=ex_mem_en=1.
    - BR_STAGE=3: flush=3'b111.
    - BR_STAGE=2: flush=3'b011.
    - Slots newer than the resolving stage are invalidated on the shift; the entering ex_q gets v=0.
    - flush_cnt += 1.
    - lu ignored.
  - lu: pc_en=0, id_ex_en=0, ex_mem_en=1, flush=3'b010 (bubble into EX); entering ex_q gets v=0; stall_cnt += 1.
  - Otherwise: all enables 1, flush=0.
- Shift when not frozen: wb_q <= mem_q, mem_q <= ex_q, ex_q <= {id_valid & id_wr_en, id_dst, id_is_load}, subject to the bubble/flush rules above.
- fwd_sel[p] is registered when not frozen:
  - 01 if match(ex_q,p) & ~ex_q.ld;
  - else 10 if match(mem_q,p);
  - else 00.
  - Forced to 00 when the entering ex_q is a bubble or flush.
  - The youngest producer wins.
- A load matched in mem_q forwards from WB (10); the matching stall has already been taken.
- wb_q producers are not forwarded. The register file provides write-before-read in the same cycle; wb_q exists only for the counters and debug.
- Counters saturate at all-ones.
- Reset asserted mid-stall or mid-flush clears state immediately; the first cycle after release behaves as an empty pipeline.

Test Plan:
- Reset: rst_n=0 mid-operation -> fwd_sel=0, counters=0, enables=1, flush=0 while low and after release.
- ALU back-to-back: add r3 then add r4,r3,r1 -> next cycle fwd_sel[1:0]=01, no stall; with one independent instruction between -> 10.
- Load-use: ld r5 then add r6,r5,r2 -> one cycle pc_en=0, flush=3'b010, stall_cnt=1; next cycle fwd_sel port0=10.
- Branch: BR_STAGE=3, br_taken=1 -> flush=3'b111 one cycle, flush_cnt=1; br_taken with lu in the same cycle -> no stall, stall_cnt unchanged.
- Freeze: mem_busy=1 for 4 cycles during a load-use stall -> all enables 0, counters and fwd_sel hold; stall resolves on release.
- R0 and unused ports: writer to r0, or id_src_use=0 with a matching specifier -> fwd_sel=00, no stall; NPORTS=3 instance checks port 2 independently.
